// File: rtl/nco_meter_pkg.sv
// Shared definitions for the NCO tone meter: FSM encoding, default sizing
// and signed min/max helpers used by the peak trackers.
package nco_meter_pkg;

    localparam int          CNT_W_DEF = 24;
    localparam logic [15:0] HYST_DEF  = 16'd64;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2,
        ST_DONE    = 2'd3
    } meter_state_e;

    function automatic logic signed [15:0] smax16(input logic signed [15:0] a,
                                                   input logic signed [15:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic signed [15:0] smin16(input logic signed [15:0] a,
                                                   input logic signed [15:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/nco_zc_detect.sv
// Rising zero-crossing detector with hysteresis: arms once the sine dips to
// -HYST or below, and fires on the next qualified non-negative sample.
module nco_zc_detect
    import nco_meter_pkg::*;
#(
    parameter logic [15:0] HYST = HYST_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_valid,
    input  logic [15:0] sin_val,
    input  logic        clear,
    output logic        crossing
);

    // 17-bit compare so any HYST up to 16'hFFFF stays representable.
    localparam logic signed [16:0] NEG_HYST = -$signed({1'b0, HYST});

    logic armed_q;
    logic armed_d;
    logic below_hyst;

    assign below_hyst = $signed({sin_val[15], sin_val}) <= NEG_HYST;
    assign crossing   = sample_valid && armed_q && !sin_val[15];

    always_comb begin
        armed_d = armed_q;
        if (clear) begin
            armed_d = 1'b0;
        end else if (crossing) begin
            armed_d = 1'b0;
        end else if (sample_valid && below_hyst) begin
            armed_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed_q <= 1'b0;
        end else begin
            armed_q <= armed_d;
        end
    end

endmodule

// File: rtl/nco_tone_meter.sv
// Measures the period of an NCO sine in valid samples over num_cycles periods,
// tracking signed peaks; a saturating sample counter bounds the measurement.
module nco_tone_meter
    import nco_meter_pkg::*;
#(
    parameter int          CNT_W = CNT_W_DEF,
    parameter logic [15:0] HYST  = HYST_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      sin_val,
    input  logic             sample_valid,
    input  logic             meas_start,
    input  logic             meas_abort,
    input  logic [7:0]       num_cycles,
    output logic             meas_busy,
    output logic             meas_done,
    output logic             timeout,
    output logic [CNT_W-1:0] period_cnt,
    output logic [15:0]      peak_pos,
    output logic [15:0]      peak_neg
);

    meter_state_e      state_q, state_d;
    logic [7:0]        ncyc_q, ncyc_d;
    logic [7:0]        xcnt_q, xcnt_d;
    logic [CNT_W-1:0]  samp_cnt_q, samp_cnt_d;
    logic [15:0]       pmax_q, pmax_d;
    logic [15:0]       pmin_q, pmin_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [15:0]       ppos_q, ppos_d;
    logic [15:0]       pneg_q, pneg_d;
    logic              timeout_q, timeout_d;

    logic              zc_clear;
    logic              crossing;
    logic [CNT_W-1:0]  cnt_inc;
    logic [15:0]       new_max;
    logic [15:0]       new_min;
    logic              last_cross;

    nco_zc_detect #(
        .HYST (HYST)
    ) u_zc (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sin_val      (sin_val),
        .clear        (zc_clear),
        .crossing     (crossing)
    );

    assign cnt_inc    = samp_cnt_q + CNT_W'(1);
    assign new_max    = smax16(pmax_q, sin_val);
    assign new_min    = smin16(pmin_q, sin_val);
    assign last_cross = crossing && (({1'b0, xcnt_q} + 9'd1) == {1'b0, ncyc_q});

    always_comb begin
        state_d    = state_q;
        ncyc_d     = ncyc_q;
        xcnt_d     = xcnt_q;
        samp_cnt_d = samp_cnt_q;
        pmax_d     = pmax_q;
        pmin_d     = pmin_q;
        period_d   = period_q;
        ppos_d     = ppos_q;
        pneg_d     = pneg_q;
        timeout_d  = timeout_q;
        zc_clear   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (meas_start) begin
                    state_d   = ST_ARM;
                    ncyc_d    = (num_cycles == 8'd0) ? 8'd1 : num_cycles;
                    xcnt_d    = 8'd0;
                    timeout_d = 1'b0;
                    zc_clear  = 1'b1;
                end
            end
            ST_ARM: begin
                if (meas_abort) begin
                    state_d = ST_IDLE;
                end else if (crossing) begin
                    // The first crossing is the time reference; it is not counted.
                    state_d    = ST_MEASURE;
                    samp_cnt_d = '0;
                    pmax_d     = sin_val;
                    pmin_d     = sin_val;
                end
            end
            ST_MEASURE: begin
                if (meas_abort) begin
                    state_d = ST_IDLE;
                end else if (sample_valid) begin
                    samp_cnt_d = cnt_inc;
                    pmax_d     = new_max;
                    pmin_d     = new_min;
                    if (crossing) begin
                        xcnt_d = xcnt_q + 8'd1;
                    end
                    if (last_cross) begin
                        state_d  = ST_DONE;
                        period_d = cnt_inc;
                        ppos_d   = new_max;
                        pneg_d   = new_min;
                    end else if (cnt_inc == '1) begin
                        state_d   = ST_DONE;
                        period_d  = '1;
                        ppos_d    = new_max;
                        pneg_d    = new_min;
                        timeout_d = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            ncyc_q     <= '0;
            xcnt_q     <= '0;
            samp_cnt_q <= '0;
            pmax_q     <= '0;
            pmin_q     <= '0;
            period_q   <= '0;
            ppos_q     <= '0;
            pneg_q     <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ncyc_q     <= ncyc_d;
            xcnt_q     <= xcnt_d;
            samp_cnt_q <= samp_cnt_d;
            pmax_q     <= pmax_d;
            pmin_q     <= pmin_d;
            period_q   <= period_d;
            ppos_q     <= ppos_d;
            pneg_q     <= pneg_d;
            timeout_q  <= timeout_d;
        end
    end

    assign meas_busy  = (state_q == ST_ARM) || (state_q == ST_MEASURE);
    assign meas_done  = (state_q == ST_DONE);
    assign timeout    = timeout_q;
    assign period_cnt = period_q;
    assign peak_pos   = ppos_q;
    assign peak_neg   = pneg_q;

endmodule

// File: tb/tb_nco_tone_meter.sv
// Directed bench for nco_tone_meter: a default-width instance plus a CNT_W=8
// instance for counter saturation, both fed the same stimulus.
module tb_nco_tone_meter;

    logic        clk;
    logic        rst;
    logic [15:0] sin_val;
    logic        sample_valid;
    logic        meas_start;
    logic        meas_abort;
    logic [7:0]  num_cycles;

    logic        busy, done, tmo;
    logic [23:0] period;
    logic [15:0] ppos, pneg;

    logic        busy8, done8, tmo8;
    logic [7:0]  period8;
    logic [15:0] ppos8, pneg8;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int done8_cnt = 0;
    int snap;

    localparam logic [15:0] P500  = 16'sd500;
    localparam logic [15:0] P1000 = 16'sd1000;
    localparam logic [15:0] N1000 = -16'sd1000;
    localparam logic [15:0] P2000 = 16'sd2000;

    nco_tone_meter dut (
        .clk(clk), .rst(rst), .sin_val(sin_val), .sample_valid(sample_valid),
        .meas_start(meas_start), .meas_abort(meas_abort), .num_cycles(num_cycles),
        .meas_busy(busy), .meas_done(done), .timeout(tmo), .period_cnt(period),
        .peak_pos(ppos), .peak_neg(pneg)
    );

    nco_tone_meter #(.CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .sin_val(sin_val), .sample_valid(sample_valid),
        .meas_start(meas_start), .meas_abort(meas_abort), .num_cycles(num_cycles),
        .meas_busy(busy8), .meas_done(done8), .timeout(tmo8), .period_cnt(period8),
        .peak_pos(ppos8), .peak_neg(pneg8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done)  done_cnt  <= done_cnt + 1;
        if (done8) done8_cnt <= done8_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] x);
        sample_valid = v;
        sin_val      = x;
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [7:0] n);
        num_cycles   = n;
        meas_start   = 1'b1;
        sample_valid = 1'b0;
        @(posedge clk);
        #1;
        meas_start   = 1'b0;
    endtask

    // Drives one valid sample, optionally preceded by an invalid cycle that
    // carries an opposite-sign value that would disturb the result if seen.
    task automatic samp(input logic [15:0] x, input logic gap);
        if (gap) drive(1'b0, x[15] ? 16'sd30000 : -16'sd30000);
        drive(1'b1, x);
    endtask

    // nper full periods (negative half first), another negative half, then
    // the single positive sample that completes the last period.
    task automatic square(input logic [15:0] amp, input int half, input int nper,
                          input logic gap, input logic abort_last);
        logic [15:0] neg;
        neg = -amp;
        for (int p = 0; p < nper; p++) begin
            for (int i = 0; i < half; i++) samp(neg, gap);
            for (int i = 0; i < half; i++) samp(amp, gap);
        end
        for (int i = 0; i < half; i++) samp(neg, gap);
        if (gap) drive(1'b0, -16'sd30000);
        meas_abort = abort_last;
        drive(1'b1, amp);
        meas_abort = 1'b0;
    endtask

    initial begin
        rst = 1'b0; sin_val = '0; sample_valid = 1'b0;
        meas_start = 1'b0; meas_abort = 1'b0; num_cycles = 8'd0;
        #1;
        check("rst_busy",   32'(busy), 32'd0);
        check("rst_done",   32'(done), 32'd0);
        check("rst_period", 32'(period), 32'd0);
        check("rst_ppos",   32'(ppos), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        drive(1'b0, 16'd0);

        // Plain square wave, 4 periods of 16.
        start(8'd4);
        check("sq_busy_arm", 32'(busy), 32'd1);
        square(P1000, 8, 4, 1'b0, 1'b0);
        check("sq_done",    32'(done), 32'd1);
        check("sq_period",  32'(period), 32'd64);
        check("sq_ppos",    32'(ppos), 32'(P1000));
        check("sq_pneg",    32'(pneg), 32'(N1000));
        check("sq_timeout", 32'(tmo), 32'd0);
        check("sq_busy_dn", 32'(busy), 32'd0);
        drive(1'b0, 16'd0);
        check("sq_done_1cy", 32'(done), 32'd0);
        check("sq_hold",     32'(period), 32'd64);

        // Same wave with an invisible cycle before every valid sample.
        start(8'd4);
        square(P1000, 8, 4, 1'b1, 1'b0);
        check("gap_done",   32'(done), 32'd1);
        check("gap_period", 32'(period), 32'd64);
        check("gap_ppos",   32'(ppos), 32'(P1000));
        check("gap_pneg",   32'(pneg), 32'(N1000));
        drive(1'b0, 16'd0);

        // num_cycles=0 behaves as one period.
        start(8'd0);
        square(P1000, 10, 1, 1'b0, 1'b0);
        check("n0_done",   32'(done), 32'd1);
        check("n0_period", 32'(period), 32'd20);
        drive(1'b0, 16'd0);

        // Noise inside the hysteresis band never arms.
        snap = done_cnt;
        start(8'd1);
        for (int i = 0; i < 30; i++) drive(1'b1, (i % 2 == 0) ? -16'sd50 : 16'sd50);
        check("nz_busy",  32'(busy), 32'd1);
        check("nz_ndone", 32'(done_cnt - snap), 32'd0);
        meas_abort = 1'b1;
        drive(1'b1, 16'sd0);
        meas_abort = 1'b0;
        check("nz_abort_idle", 32'(busy), 32'd0);

        // Abort mid-MEASURE.
        start(8'd3);
        for (int i = 0; i < 8; i++) drive(1'b1, -P2000);
        for (int i = 0; i < 8; i++) drive(1'b1, P2000);
        check("ab_busy_meas", 32'(busy), 32'd1);
        meas_abort = 1'b1;
        drive(1'b1, -P2000);
        meas_abort = 1'b0;
        check("ab_mid_idle", 32'(busy), 32'd0);

        // Abort coinciding with the completing crossing wins.
        snap = done_cnt;
        start(8'd1);
        square(P2000, 8, 1, 1'b0, 1'b1);
        check("ab_fin_done",   32'(done), 32'd0);
        check("ab_fin_busy",   32'(busy), 32'd0);
        check("ab_fin_period", 32'(period), 32'd20);
        check("ab_fin_ppos",   32'(ppos), 32'(P1000));
        check("ab_fin_pneg",   32'(pneg), 32'(N1000));
        drive(1'b0, 16'd0);
        check("ab_fin_ndone", 32'(done_cnt - snap), 32'd0);

        // Saturation on the 8-bit instance.
        start(8'd4);
        for (int i = 0; i < 4; i++) drive(1'b1, N1000);
        for (int i = 0; i < 255; i++) drive(1'b1, P500);
        check("to_pre_done", 32'(done8), 32'd0);
        drive(1'b1, P500);
        check("to_done",    32'(done8), 32'd1);
        check("to_timeout", 32'(tmo8), 32'd1);
        check("to_period",  32'(period8), 32'd255);
        check("to_ppos",    32'(ppos8), 32'(P500));
        check("to_pneg",    32'(pneg8), 32'(P500));
        check("to_wide_busy", 32'(busy), 32'd1);
        drive(1'b0, 16'd0);
        check("to_done_1cy", 32'(done8), 32'd0);

        // Reset in ARM: immediate clear, no completion afterwards.
        start(8'd1);
        drive(1'b1, N1000);
        check("rs_busy_arm", 32'(busy8), 32'd1);
        snap = done8_cnt;
        rst = 1'b0;
        #1;
        check("rs_busy",    32'(busy8), 32'd0);
        check("rs_done",    32'(done8), 32'd0);
        check("rs_timeout", 32'(tmo8), 32'd0);
        check("rs_period",  32'(period8), 32'd0);
        check("rs_ppos",    32'(ppos8), 32'd0);
        check("rs_pneg",    32'(pneg8), 32'd0);
        check("rs_wide_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) drive(1'b1, P1000);
        check("rs_after_busy",  32'(busy8), 32'd0);
        check("rs_after_ndone", 32'(done8_cnt - snap), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nco_tone_meter.md
NCO_TONE_METER -- requirements
Module: nco_tone_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 24: width of the sample counter and period_cnt.
REQ-002 SHALL have parameter HYST, default 16'd64: unsigned hysteresis magnitude used for crossing arming.
REQ-003 SHALL have port clk  input  1: clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port sin_val  input  16: signed two's-complement sine sample from the NCO path.
REQ-006 SHALL have port sample_valid  input  1: sin_val is qualified this cycle.
REQ-007 SHALL have port meas_start  input  1: single-cycle start request.
REQ-008 SHALL have port meas_abort  input  1: level abort request.
REQ-009 SHALL have port num_cycles  input  8: number of sine periods to measure; sampled at start.
REQ-010 SHALL have port meas_busy  output  1: a measurement is in progress (ARM or MEASURE).
REQ-011 SHALL have port meas_done  output  1: single-cycle completion pulse.
REQ-012 SHALL have port timeout  output  1: last measurement ended by counter saturation.
REQ-013 SHALL have port period_cnt  output  CNT_W: valid samples spanning num_cycles periods.
REQ-014 SHALL have port peak_pos  output  16: signed maximum sample during MEASURE.
REQ-015 SHALL have port peak_neg  output  16: signed minimum sample during MEASURE.

Function
REQ-016 SHALL implement states IDLE, ARM, MEASURE, DONE.
REQ-017 SHALL set an internal armed flag on a valid sample with sin_val <= -HYST (signed compare) and clear it on each detected crossing.
REQ-018 SHALL define a rising crossing as sample_valid=1, armed=1, sin_val >= 0.
REQ-019 SHALL leave IDLE for ARM on meas_start=1, latching num_cycles (0 treated as 1) and clearing armed, timeout, and the crossing count.
REQ-020 SHALL ignore meas_start while in ARM, MEASURE or DONE.
REQ-021 SHALL move ARM->MEASURE on the first crossing, setting the sample counter to 0 and both peak registers to that crossing sample.
REQ-022 SHALL increment the sample counter by 1 on every valid sample in MEASURE, including the sample that produces a crossing.
REQ-023 SHALL update peak_pos/peak_neg on every valid MEASURE sample using signed max/min.
REQ-024 SHALL move MEASURE->DONE on the crossing that brings the crossing count to the latched num_cycles, loading period_cnt with the incremented counter value (a period-P input gives N*P).
REQ-025 SHALL, if the sample counter reaches 2^CNT_W-1 in MEASURE, saturate it, load period_cnt with all-ones, set timeout=1, and move to DONE.
REQ-026 SHALL assert meas_done for exactly one cycle in DONE, then return to IDLE; meas_done rises one cycle after the completing sample.
REQ-027 SHALL treat sample_valid=0 cycles as invisible: no count, no arming, no crossing.
REQ-028 SHALL, on meas_abort=1 in ARM or MEASURE, return to IDLE next cycle without meas_done and leave period_cnt, peak_pos, peak_neg and timeout unchanged; abort takes priority over a same-cycle completion.
REQ-029 SHALL hold period_cnt, peak_pos, peak_neg and timeout stable from DONE until the next completion.
REQ-030 SHALL drive meas_busy=1 exactly in ARM and MEASURE.

Reset
REQ-031 SHALL, on rst=0, force IDLE and clear meas_busy, meas_done, timeout, period_cnt, peak_pos, peak_neg, armed, counters and latched num_cycles immediately.
REQ-032 SHALL, on reset mid-measurement, discard the measurement with no meas_done after release.

Structure
REQ-033 SHALL take the state enumeration and the default CNT_W/HYST constants from shared package nco_meter_pkg.
REQ-034 SHALL place armed-flag and crossing detection in sub-module nco_zc_detect (inputs clk, rst, sample_valid, sin_val, clear; output crossing pulse).

Verification
REQ-035 SHALL cover: square wave +1000/-1000, period 16 samples, sample_valid=1, num_cycles=4 -> meas_done, period_cnt=64, peak_pos=1000, peak_neg=-1000, timeout=0.
REQ-036 SHALL cover: same stimulus with sample_valid low every other cycle -> period_cnt=64 (valid samples only).
REQ-037 SHALL cover: num_cycles=0, period 20 -> period_cnt=20.
REQ-038 SHALL cover: noise between -50 and +50 with HYST=64 after start -> no crossing, remains ARM, meas_busy=1, no meas_done.
REQ-039 SHALL cover: meas_abort asserted in MEASURE, including the cycle of the final crossing -> IDLE, no meas_done, prior results unchanged.
REQ-040 SHALL cover: CNT_W=8, constant +500 after first crossing -> timeout=1, period_cnt=255, meas_done pulse; then rst=0 mid-ARM -> all outputs 0.
